// File: rtl/game_pkg.sv
// Shared types and helpers for the round controller: phases, directions,
// and the reversal/initial-direction rules.
package game_pkg;

   typedef enum logic [1:0] {
      PH_IDLE  = 2'd0,
      PH_COUNT = 2'd1,
      PH_PLAY  = 2'd2,
      PH_OVER  = 2'd3
   } phase_t;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_RIGHT = 2'd1,
      DIR_DOWN  = 2'd2,
      DIR_LEFT  = 2'd3
   } dir_t;

   localparam int CD_W = 2;

   function automatic dir_t opposite(input dir_t d);
      return dir_t'(d ^ 2'd2);
   endfunction

   // Even players start heading right, odd players left, so neighbours face each other.
   function automatic dir_t init_dir(input int idx);
      return (idx % 2 == 0) ? DIR_RIGHT : DIR_LEFT;
   endfunction

endpackage

// File: rtl/game_tick_gen.sv
// Game tick divider: counts 0..DIV-1 while enabled, tick is high on the last count.
module game_tick_gen #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
      end
   end

   assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/game_round_ctrl.sv
// Round/match controller: direction arbitration with reversal rejection,
// step generation, IDLE/COUNT/PLAY/OVER round FSM, scoring and debug word.
module game_round_ctrl
   import game_pkg::*;
#(
   parameter int NUM_PLAYERS = 2,
   parameter int TICK_DIV    = 25_000_000,
   parameter int COUNTDOWN   = 3,
   parameter int SCORE_W     = 8,
   parameter int WIN_SCORE   = 5,
   localparam int WID_W      = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic [NUM_PLAYERS-1:0]         ai_en,
   input  logic [2*NUM_PLAYERS-1:0]       key_dir,
   input  logic [NUM_PLAYERS-1:0]         key_valid,
   input  logic [2*NUM_PLAYERS-1:0]       ai_dir,
   input  logic [NUM_PLAYERS-1:0]         alive,
   output logic [1:0]                     phase,
   output logic [1:0]                     cd,
   output logic                           step,
   output logic [2*NUM_PLAYERS-1:0]       dir_out,
   output logic [SCORE_W*NUM_PLAYERS-1:0] score,
   output logic [WID_W-1:0]               winner,
   output logic                           winner_valid,
   output logic                           match_over,
   output logic [15:0]                    dbg
);

   localparam bit SURVIVAL = (NUM_PLAYERS == 1);
   localparam int CNT_W    = $clog2(NUM_PLAYERS + 1);
   localparam logic [SCORE_W-1:0] WIN_S = SCORE_W'(WIN_SCORE);

   phase_t               ph;
   logic [CD_W-1:0]      cd_r;
   logic                 step_r;
   logic [WID_W-1:0]     winner_r;
   logic                 wv_r;
   logic                 mo_r;
   dir_t                 dir_r  [NUM_PLAYERS];
   dir_t                 pend   [NUM_PLAYERS];
   dir_t                 cand   [NUM_PLAYERS];
   logic [SCORE_W-1:0]   score_r[NUM_PLAYERS];
   logic [NUM_PLAYERS-1:0] accept;

   logic                 tick;
   logic                 tick_clr;
   logic [CNT_W-1:0]     alive_cnt;
   logic [WID_W-1:0]     lone_idx;
   logic [SCORE_W-1:0]   lone_score;
   logic                 any_win;
   logic                 lone_wins;

   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
      return (s == '1) ? s : s + SCORE_W'(1);
   endfunction

   // The counter only runs while a round is active; holding it clear elsewhere
   // makes every COUNT/PLAY entry start from zero.
   assign tick_clr = (ph == PH_IDLE) || (ph == PH_OVER);

   game_tick_gen #(
      .DIV (TICK_DIV)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (tick_clr),
      .en    (!tick_clr),
      .tick  (tick)
   );

   for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_arb
      logic [1:0] src;
      logic       src_valid;
      assign src       = ai_en[i] ? ai_dir[2*i +: 2] : key_dir[2*i +: 2];
      assign src_valid = ai_en[i] | key_valid[i];
      assign cand[i]   = dir_t'(src);
      assign accept[i] = src_valid && (cand[i] != opposite(dir_r[i]));
      assign dir_out[2*i +: 2]          = dir_r[i];
      assign score[SCORE_W*i +: SCORE_W] = score_r[i];
   end

   always_comb begin
      alive_cnt  = '0;
      lone_idx   = '0;
      lone_score = '0;
      any_win    = 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         if (alive[i]) begin
            alive_cnt  = alive_cnt + CNT_W'(1);
            lone_idx   = WID_W'(i);
            lone_score = score_r[i];
         end
         if (score_r[i] >= WIN_S) begin
            any_win = 1'b1;
         end
      end
      lone_wins = (sat_inc(lone_score) >= WIN_S);
   end

   // Round FSM; all outputs are registered here so round-end updates land on one edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ph       <= PH_IDLE;
         cd_r     <= '0;
         step_r   <= 1'b0;
         winner_r <= '0;
         wv_r     <= 1'b0;
         mo_r     <= 1'b0;
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            score_r[i] <= '0;
            dir_r[i]   <= init_dir(i);
            pend[i]    <= init_dir(i);
         end
      end else begin
         step_r <= 1'b0;
         case (ph)
            PH_IDLE: begin
               if (start) begin
                  ph   <= PH_COUNT;
                  cd_r <= CD_W'(COUNTDOWN);
                  for (int i = 0; i < NUM_PLAYERS; i++) begin
                     dir_r[i] <= init_dir(i);
                     pend[i]  <= init_dir(i);
                  end
               end
            end
            PH_COUNT: begin
               if (tick) begin
                  if (cd_r == CD_W'(1)) begin
                     ph   <= PH_PLAY;
                     cd_r <= '0;
                  end else begin
                     cd_r <= cd_r - CD_W'(1);
                  end
               end
            end
            PH_PLAY: begin
               for (int i = 0; i < NUM_PLAYERS; i++) begin
                  if (accept[i]) begin
                     pend[i] <= cand[i];
                  end
               end
               // A death on a tick edge ends the round first, so that tick neither steps nor scores.
               if (SURVIVAL) begin
                  if (!alive[0]) begin
                     ph <= PH_OVER;
                  end else if (tick) begin
                     step_r     <= 1'b1;
                     score_r[0] <= sat_inc(score_r[0]);
                     for (int i = 0; i < NUM_PLAYERS; i++) begin
                        dir_r[i] <= pend[i];
                     end
                  end
               end else if (alive_cnt == CNT_W'(1)) begin
                  ph       <= PH_OVER;
                  winner_r <= lone_idx;
                  wv_r     <= 1'b1;
                  mo_r     <= any_win || lone_wins;
                  for (int i = 0; i < NUM_PLAYERS; i++) begin
                     if (alive[i]) begin
                        score_r[i] <= sat_inc(score_r[i]);
                     end
                  end
               end else if (alive_cnt == '0) begin
                  ph   <= PH_OVER;
                  wv_r <= 1'b0;
                  mo_r <= any_win;
               end else if (tick) begin
                  step_r <= 1'b1;
                  for (int i = 0; i < NUM_PLAYERS; i++) begin
                     dir_r[i] <= pend[i];
                  end
               end
            end
            PH_OVER: begin
               if (start) begin
                  if (mo_r) begin
                     wv_r <= 1'b0;
                     mo_r <= 1'b0;
                     for (int i = 0; i < NUM_PLAYERS; i++) begin
                        score_r[i] <= '0;
                     end
                  end
                  ph   <= PH_COUNT;
                  cd_r <= CD_W'(COUNTDOWN);
                  for (int i = 0; i < NUM_PLAYERS; i++) begin
                     dir_r[i] <= init_dir(i);
                     pend[i]  <= init_dir(i);
                  end
               end
            end
            default: begin
               ph <= PH_IDLE;
            end
         endcase
      end
   end

   logic [3:0] s1_nib;
   if (NUM_PLAYERS > 1) begin : g_s1
      assign s1_nib = 4'(score_r[1]);
   end else begin : g_s1_none
      assign s1_nib = 4'd0;
   end

   assign phase        = ph;
   assign cd           = cd_r;
   assign step         = step_r;
   assign winner       = winner_r;
   assign winner_valid = wv_r;
   assign match_over   = mo_r;
   assign dbg          = {ph, cd_r, 4'(winner_r), 4'(score_r[0]), s1_nib};

endmodule

// File: tb/tb_game_round_ctrl.sv
// Scoreboard bench for game_round_ctrl: a two-player instance and a survival
// instance share clock and reset; expectations are queued at drive time.
module tb_game_round_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic       start0;
   logic [1:0] ai_en0, key_valid0, alive0;
   logic [3:0] key_dir0, ai_dir0;
   logic [1:0] phase0, cd0;
   logic       step0;
   logic [3:0] dir0;
   logic [15:0] score0;
   logic [0:0] winner0;
   logic       wv0, mo0;
   logic [15:0] dbg0;

   logic       start1;
   logic [0:0] ai_en1, key_valid1, alive1;
   logic [1:0] key_dir1, ai_dir1;
   logic [1:0] phase1, cd1;
   logic       step1;
   logic [1:0] dir1;
   logic [7:0] score1;
   logic [0:0] winner1;
   logic       wv1, mo1;
   logic [15:0] dbg1;

   game_round_ctrl #(
      .NUM_PLAYERS (2), .TICK_DIV (4), .COUNTDOWN (3), .SCORE_W (8), .WIN_SCORE (2)
   ) dut (
      .clk (clk), .rst_n (rst_n), .start (start0), .ai_en (ai_en0),
      .key_dir (key_dir0), .key_valid (key_valid0), .ai_dir (ai_dir0), .alive (alive0),
      .phase (phase0), .cd (cd0), .step (step0), .dir_out (dir0), .score (score0),
      .winner (winner0), .winner_valid (wv0), .match_over (mo0), .dbg (dbg0)
   );

   game_round_ctrl #(
      .NUM_PLAYERS (1), .TICK_DIV (4), .COUNTDOWN (3), .SCORE_W (8), .WIN_SCORE (2)
   ) dut_surv (
      .clk (clk), .rst_n (rst_n), .start (start1), .ai_en (ai_en1),
      .key_dir (key_dir1), .key_valid (key_valid1), .ai_dir (ai_dir1), .alive (alive1),
      .phase (phase1), .cd (cd1), .step (step1), .dir_out (dir1), .score (score1),
      .winner (winner1), .winner_valid (wv1), .match_over (mo1), .dbg (dbg1)
   );

   typedef struct packed {
      logic [31:0] val;
      logic [31:0] mask;
   } exp_t;

   exp_t exp_q[$];
   int total = 0;
   int bad   = 0;
   int stray_steps = 0;
   int steps_surv  = 0;

   localparam logic [31:0] M0       = 32'h0FFF_FFFF;
   localparam logic [31:0] M0_NODIR = 32'h0FFF_FFFF & ~32'h0078_0000;
   localparam logic [31:0] M0_NDNM  = 32'h0FFF_FFFF & ~32'h0078_0001;
   localparam logic [31:0] M1       = 32'h0003_FFFF;
   localparam logic [31:0] M16      = 32'h0000_FFFF;

   always @(negedge clk) begin
      if (step0 && phase0 != 2'd2) stray_steps++;
      if (step1 && phase1 != 2'd2) stray_steps++;
      if (step1) steps_surv++;
   end

   function automatic logic [31:0] snap0();
      return {4'b0, phase0, cd0, step0, dir0, score0, winner0, wv0, mo0};
   endfunction

   function automatic logic [31:0] snap1();
      return {14'b0, phase1, cd1, step1, dir1, score1, winner1, wv1, mo1};
   endfunction

   function automatic logic [31:0] exp0(input logic [1:0] ph, input logic [1:0] c, input logic st,
                                        input logic [3:0] d, input logic [15:0] sc,
                                        input logic w, input logic v, input logic m);
      return {4'b0, ph, c, st, d, sc, w, v, m};
   endfunction

   function automatic logic [31:0] exp1(input logic [1:0] ph, input logic [1:0] c, input logic st,
                                        input logic [1:0] d, input logic [7:0] sc,
                                        input logic w, input logic v, input logic m);
      return {14'b0, ph, c, st, d, sc, w, v, m};
   endfunction

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start0();
      start0 = 1'b1;
      cyc(1);
      start0 = 1'b0;
   endtask

   task automatic pulse_start1();
      start1 = 1'b1;
      cyc(1);
      start1 = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e;
      logic [31:0] obs;
      rst_n = 1'b0;
      cyc(2);
      exp_q.push_back({exp0(2'd0, 2'd0, 1'b0, 4'b1101, 16'h0, 1'b0, 1'b0, 1'b0), M0});
      exp_q.push_back({exp1(2'd0, 2'd0, 1'b0, 2'b01, 8'h0, 1'b0, 1'b0, 1'b0), M1});
      exp_q.push_back({32'h0, M16});
      rst_n = 1'b1;
      cyc(1);
      e = exp_q.pop_front(); obs = snap0() & e.mask; total++;
      if (obs !== (e.val & e.mask)) begin bad++; $display("[TB] FAIL reset_p2: got %h want %h", obs, e.val & e.mask); end
      e = exp_q.pop_front(); obs = snap1() & e.mask; total++;
      if (obs !== (e.val & e.mask)) begin bad++; $display("[TB] FAIL reset_surv: got %h want %h", obs, e.val & e.mask); end
      e = exp_q.pop_front(); obs = {16'h0, dbg0} & e.mask; total++;
      if (obs !== (e.val & e.mask)) begin bad++; $display("[TB] FAIL reset_dbg: got %h want %h", obs, e.val & e.mask); end
   endtask

   task automatic test_countdown();
      exp_t e;
      logic [31:0] obs;
      int offs[7] = '{0, 3, 4, 8, 12, 15, 16};
      int prev = 0;
      alive0 = 2'b11;
      exp_q.push_back({exp0(2'd1, 2'd3, 1'b0, 4'b1101, 16'h0, 1'b0, 1'b0, 1'b0), M0});
      exp_q.push_back({exp0(2'd1, 2'd3, 1'b0, 4'b1101, 16'h0, 1'b0, 1'b0, 1'b0), M0});
      exp_q.push_back({exp0(2'd1, 2'd2, 1'b0, 4'b1101, 16'h0, 1'b0, 1'b0, 1'b0), M0});
      exp_q.push_back({exp0(2'd1, 2'd1, 1'b0, 4'b1101, 16'h0, 1'b0, 1'b0, 1'b0), M0});
      exp_q.push_back({exp0(2'd2, 2'd0, 1'b0, 4'b1101, 16'h0, 1'b0, 1'b0, 1'b0), M0});
      exp_q.push_back({exp0(2'd2, 2'd0, 1'b0, 4'b1101, 16'h0, 1'b0, 1'b0, 1'b0), M0});
      exp_q.push_back({exp0(2'd2, 2'd0, 1'b1, 4'b1101, 16'h0, 1'b0, 1'b0, 1'b0), M0});
      pulse_start0();
      for (int k = 0; k < 7; k++) begin
         cyc(offs[k] - prev);
         prev = offs[k];
         e = exp_q.pop_front(); obs = snap0() & e.mask; total++;
         if (obs !== (e.val & e.mask)) begin bad++; $display("[TB] FAIL countdown_%0d: got %h want %h", offs[k], obs, e.val & e.mask); end
      end
   endtask

   task automatic test_direction();
      exp_t e;
      logic [31:0] obs;
      key_dir0   = 4'b0011;
      key_valid0 = 2'b01;
      exp_q.push_back({exp0(2'd2, 2'd0, 1'b1, 4'b1101, 16'h0, 1'b0, 1'b0, 1'b0), M0});
      cyc(1);
      key_valid0 = 2'b00;
      cyc(3);
      e = exp_q.pop_front(); obs = snap0() & e.mask; total++;
      if (obs !== (e.val & e.mask)) begin bad++; $display("[TB] FAIL reversal_reject: got %h want %h", obs, e.val & e.mask); end
      key_dir0   = 4'b0000;
      key_valid0 = 2'b01;
      ai_en0     = 2'b10;
      ai_dir0    = 4'b1000;
      exp_q.push_back({exp0(2'd2, 2'd0, 1'b0, 4'b1101, 16'h0, 1'b0, 1'b0, 1'b0), M0});
      exp_q.push_back({exp0(2'd2, 2'd0, 1'b1, 4'b1000, 16'h0, 1'b0, 1'b0, 1'b0), M0});
      cyc(1);
      key_valid0 = 2'b00;
      cyc(2);
      e = exp_q.pop_front(); obs = snap0() & e.mask; total++;
      if (obs !== (e.val & e.mask)) begin bad++; $display("[TB] FAIL dir_before_step: got %h want %h", obs, e.val & e.mask); end
      cyc(1);
      e = exp_q.pop_front(); obs = snap0() & e.mask; total++;
      if (obs !== (e.val & e.mask)) begin bad++; $display("[TB] FAIL dir_at_step: got %h want %h", obs, e.val & e.mask); end
      ai_en0 = 2'b00;
   endtask

   task automatic test_round_win();
      exp_t e;
      logic [31:0] obs;
      alive0 = 2'b01;
      exp_q.push_back({exp0(2'd3, 2'd0, 1'b0, 4'b1000, 16'h0001, 1'b0, 1'b1, 1'b0), M0});
      exp_q.push_back({exp0(2'd3, 2'd0, 1'b0, 4'b1000, 16'h0001, 1'b0, 1'b1, 1'b0), M0});
      cyc(1);
      e = exp_q.pop_front(); obs = snap0() & e.mask; total++;
      if (obs !== (e.val & e.mask)) begin bad++; $display("[TB] FAIL p0_win: got %h want %h", obs, e.val & e.mask); end
      cyc(2);
      e = exp_q.pop_front(); obs = snap0() & e.mask; total++;
      if (obs !== (e.val & e.mask)) begin bad++; $display("[TB] FAIL over_hold: got %h want %h", obs, e.val & e.mask); end
   endtask

   task automatic test_draw();
      exp_t e;
      logic [31:0] obs;
      alive0 = 2'b11;
      exp_q.push_back({exp0(2'd1, 2'd3, 1'b0, 4'b0, 16'h0001, 1'b0, 1'b1, 1'b0), M0_NODIR});
      exp_q.push_back({exp0(2'd2, 2'd0, 1'b0, 4'b0, 16'h0001, 1'b0, 1'b1, 1'b0), M0_NODIR});
      pulse_start0();
      e = exp_q.pop_front(); obs = snap0() & e.mask; total++;
      if (obs !== (e.val & e.mask)) begin bad++; $display("[TB] FAIL restart_keep: got %h want %h", obs, e.val & e.mask); end
      cyc(12);
      e = exp_q.pop_front(); obs = snap0() & e.mask; total++;
      if (obs !== (e.val & e.mask)) begin bad++; $display("[TB] FAIL draw_play: got %h want %h", obs, e.val & e.mask); end
      alive0 = 2'b00;
      exp_q.push_back({exp0(2'd3, 2'd0, 1'b0, 4'b0, 16'h0001, 1'b0, 1'b0, 1'b0), M0_NODIR});
      cyc(1);
      e = exp_q.pop_front(); obs = snap0() & e.mask; total++;
      if (obs !== (e.val & e.mask)) begin bad++; $display("[TB] FAIL draw_over: got %h want %h", obs, e.val & e.mask); end
   endtask

   task automatic test_match();
      exp_t e;
      logic [31:0] obs;
      alive0 = 2'b11;
      exp_q.push_back({exp0(2'd2, 2'd0, 1'b0, 4'b0, 16'h0001, 1'b0, 1'b0, 1'b0), M0_NODIR});
      exp_q.push_back({exp0(2'd2, 2'd0, 1'b0, 4'b0, 16'h0001, 1'b0, 1'b0, 1'b0), M0_NODIR});
      pulse_start0();
      cyc(12);
      e = exp_q.pop_front(); obs = snap0() & e.mask; total++;
      if (obs !== (e.val & e.mask)) begin bad++; $display("[TB] FAIL match_a_play: got %h want %h", obs, e.val & e.mask); end
      pulse_start0();
      e = exp_q.pop_front(); obs = snap0() & e.mask; total++;
      if (obs !== (e.val & e.mask)) begin bad++; $display("[TB] FAIL start_in_play: got %h want %h", obs, e.val & e.mask); end
      alive0 = 2'b10;
      exp_q.push_back({exp0(2'd3, 2'd0, 1'b0, 4'b0, 16'h0101, 1'b1, 1'b1, 1'b0), M0_NODIR});
      cyc(1);
      e = exp_q.pop_front(); obs = snap0() & e.mask; total++;
      if (obs !== (e.val & e.mask)) begin bad++; $display("[TB] FAIL p1_win_a: got %h want %h", obs, e.val & e.mask); end

      alive0 = 2'b11;
      pulse_start0();
      cyc(12);
      alive0 = 2'b10;
      exp_q.push_back({exp0(2'd3, 2'd0, 1'b0, 4'b0, 16'h0201, 1'b1, 1'b1, 1'b0), M0_NDNM});
      exp_q.push_back({exp0(2'd3, 2'd0, 1'b0, 4'b0, 16'h0201, 1'b1, 1'b1, 1'b1), M0_NODIR});
      exp_q.push_back({32'h0000_C112, M16});
      cyc(1);
      e = exp_q.pop_front(); obs = snap0() & e.mask; total++;
      if (obs !== (e.val & e.mask)) begin bad++; $display("[TB] FAIL p1_win_b: got %h want %h", obs, e.val & e.mask); end
      cyc(1);
      e = exp_q.pop_front(); obs = snap0() & e.mask; total++;
      if (obs !== (e.val & e.mask)) begin bad++; $display("[TB] FAIL match_over_set: got %h want %h", obs, e.val & e.mask); end
      e = exp_q.pop_front(); obs = {16'h0, dbg0} & e.mask; total++;
      if (obs !== (e.val & e.mask)) begin bad++; $display("[TB] FAIL dbg_over: got %h want %h", obs, e.val & e.mask); end

      alive0 = 2'b11;
      exp_q.push_back({exp0(2'd1, 2'd3, 1'b0, 4'b0, 16'h0000, 1'b1, 1'b0, 1'b0), M0_NODIR});
      pulse_start0();
      e = exp_q.pop_front(); obs = snap0() & e.mask; total++;
      if (obs !== (e.val & e.mask)) begin bad++; $display("[TB] FAIL match_restart: got %h want %h", obs, e.val & e.mask); end
   endtask

   task automatic test_survival();
      exp_t e;
      logic [31:0] obs;
      int base;
      alive1 = 1'b1;
      base = steps_surv;
      exp_q.push_back({exp1(2'd1, 2'd3, 1'b0, 2'b01, 8'd0, 1'b0, 1'b0, 1'b0), M1});
      exp_q.push_back({exp1(2'd2, 2'd0, 1'b0, 2'b01, 8'd0, 1'b0, 1'b0, 1'b0), M1});
      exp_q.push_back({exp1(2'd2, 2'd0, 1'b1, 2'b01, 8'd5, 1'b0, 1'b0, 1'b0), M1});
      pulse_start1();
      e = exp_q.pop_front(); obs = snap1() & e.mask; total++;
      if (obs !== (e.val & e.mask)) begin bad++; $display("[TB] FAIL surv_count: got %h want %h", obs, e.val & e.mask); end
      cyc(12);
      e = exp_q.pop_front(); obs = snap1() & e.mask; total++;
      if (obs !== (e.val & e.mask)) begin bad++; $display("[TB] FAIL surv_play: got %h want %h", obs, e.val & e.mask); end
      cyc(20);
      e = exp_q.pop_front(); obs = snap1() & e.mask; total++;
      if (obs !== (e.val & e.mask)) begin bad++; $display("[TB] FAIL surv_step5: got %h want %h", obs, e.val & e.mask); end
      cyc(3);
      alive1 = 1'b0;
      exp_q.push_back({exp1(2'd3, 2'd0, 1'b0, 2'b01, 8'd5, 1'b0, 1'b0, 1'b0), M1});
      exp_q.push_back({32'd5, 32'hFFFF_FFFF});
      cyc(1);
      e = exp_q.pop_front(); obs = snap1() & e.mask; total++;
      if (obs !== (e.val & e.mask)) begin bad++; $display("[TB] FAIL surv_death_tick: got %h want %h", obs, e.val & e.mask); end
      cyc(2);
      e = exp_q.pop_front(); obs = 32'(steps_surv - base); total++;
      if (obs !== e.val) begin bad++; $display("[TB] FAIL surv_step_count: got %0d want %0d", obs, e.val); end
   endtask

   task automatic test_reset_mid_play();
      exp_t e;
      logic [31:0] obs;
      alive1 = 1'b1;
      pulse_start1();
      cyc(19);
      rst_n = 1'b0;
      exp_q.push_back({exp1(2'd0, 2'd0, 1'b0, 2'b01, 8'd0, 1'b0, 1'b0, 1'b0), M1});
      exp_q.push_back({exp0(2'd0, 2'd0, 1'b0, 4'b1101, 16'h0, 1'b0, 1'b0, 1'b0), M0});
      cyc(1);
      e = exp_q.pop_front(); obs = snap1() & e.mask; total++;
      if (obs !== (e.val & e.mask)) begin bad++; $display("[TB] FAIL midplay_reset_surv: got %h want %h", obs, e.val & e.mask); end
      e = exp_q.pop_front(); obs = snap0() & e.mask; total++;
      if (obs !== (e.val & e.mask)) begin bad++; $display("[TB] FAIL midplay_reset_p2: got %h want %h", obs, e.val & e.mask); end
      rst_n = 1'b1;
      cyc(2);
   endtask

   task automatic test_step_monitor();
      exp_t e;
      exp_q.push_back({32'd0, 32'hFFFF_FFFF});
      e = exp_q.pop_front(); total++;
      if (32'(stray_steps) !== e.val) begin bad++; $display("[TB] FAIL step_outside_play: got %0d want %0d", stray_steps, e.val); end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n      = 1'b0;
      start0     = 1'b0;
      ai_en0     = 2'b00;
      key_valid0 = 2'b00;
      key_dir0   = 4'b0000;
      ai_dir0    = 4'b0000;
      alive0     = 2'b11;
      start1     = 1'b0;
      ai_en1     = 1'b0;
      key_valid1 = 1'b0;
      key_dir1   = 2'b00;
      ai_dir1    = 2'b00;
      alive1     = 1'b1;
      test_reset();
      test_countdown();
      test_direction();
      test_round_win();
      test_draw();
      test_match();
      test_survival();
      test_reset_mid_play();
      test_step_monitor();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
